// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct
// codes, ALU operation codes, mux select codes and the controller states.
package mips_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Funct field IR[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALURESULT = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_JUMP      = 2'b10;

    // Controller states, 4-bit binary
    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTE  = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_ADDIEXEC = 4'd10,
        ST_ADDIWB   = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decode, with a flag marking supported functs.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_controls,
    output logic       valid
);

    // Map funct to ALU code; unsupported functs fall back to add and clear valid
    always_comb begin
        alu_controls = ALU_ADD;
        valid        = 1'b1;
        case (funct)
            FN_ADD:  alu_controls = ALU_ADD;
            FN_SUB:  alu_controls = ALU_SUB;
            FN_AND:  alu_controls = ALU_AND;
            FN_OR:   alu_controls = ALU_OR;
            FN_SLT:  alu_controls = ALU_SLT;
            default: valid        = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing controller: Moore state outputs with Mealy
// handshake terms on mem_ready (FETCH, MEMWRITE) and zero (BRANCH).
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_controls,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    logic [2:0] rtype_alu;
    logic       funct_valid;
    logic       op_legal;

    alu_decoder u_alu_decoder (
        .funct        (funct),
        .alu_controls (rtype_alu),
        .valid        (funct_valid)
    );

    assign op_legal = ((Opcode == OP_RTYPE) && funct_valid) ||
                      (Opcode == OP_J)   || (Opcode == OP_BEQ) ||
                      (Opcode == OP_ADDI) || (Opcode == OP_LW) ||
                      (Opcode == OP_SW);

    // State register with async clear; wait states hold on mem_ready low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET:    state <= ST_FETCH;
                ST_FETCH:    if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    if (!op_legal)                                state <= ST_FETCH;
                    else if (Opcode == OP_LW || Opcode == OP_SW) state <= ST_MEMADR;
                    else if (Opcode == OP_RTYPE)                 state <= ST_EXECUTE;
                    else if (Opcode == OP_ADDI)                  state <= ST_ADDIEXEC;
                    else if (Opcode == OP_BEQ)                   state <= ST_BRANCH;
                    else                                         state <= ST_JUMP;
                end
                ST_MEMADR:   state <= (Opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
                ST_MEMREAD:  if (mem_ready) state <= ST_MEMWB;
                ST_MEMWRITE: if (mem_ready) state <= ST_FETCH;
                ST_EXECUTE:  state <= ST_ALUWB;
                ST_ADDIEXEC: state <= ST_ADDIWB;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    // Control outputs decoded from state plus the handshake/flag terms
    always_comb begin
        mem_req      = 1'b0;
        memWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        regDst       = 1'b0;
        memToReg     = 1'b0;
        regWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        ALU_controls = ALU_ADD;
        PCSrc        = PC_ALURESULT;
        PCEn         = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        case (state)
            ST_RESET: ALU_controls = 3'b000;
            ST_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                illegal_op = !op_legal;
                instr_done = !op_legal;
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                memToReg   = 1'b1;
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_req    = 1'b1;
                memWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXECUTE: begin
                ALUSrcA      = 1'b1;
                ALU_controls = rtype_alu;
            end
            ST_ALUWB: begin
                regDst     = 1'b1;
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALU_controls = ALU_SUB;
                PCSrc        = PC_ALUOUT;
                PCEn         = zero;
                instr_done   = 1'b1;
            end
            ST_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_ADDIWB: begin
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                PCSrc      = PC_JUMP;
                PCEn       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, random
// instruction stream against a per-instruction reference model, and an
// asynchronous reset abort sequence.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memWrite, IorD, IRWrite, regDst, memToReg, regWrite;
    logic       ALUSrcA, PCEn, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALU_controls;
    logic [17:0] outs;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    multicycle_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Opcode       (Opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .memWrite     (memWrite),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .regDst       (regDst),
        .memToReg     (memToReg),
        .regWrite     (regWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALU_controls (ALU_controls),
        .PCSrc        (PCSrc),
        .PCEn         (PCEn),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op)
    );

    assign outs = {mem_req, memWrite, IorD, IRWrite, regDst, memToReg, regWrite,
                   ALUSrcA, ALUSrcB, ALU_controls, PCSrc, PCEn, instr_done, illegal_op};

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction starting in FETCH (called at posedge+1).
    // The model derives everything from the instruction class and wait counts.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int unsigned wf, input int unsigned wm,
                             output int unsigned cycles, output int unsigned n_rw);
        bit          fn_ok, legal, is_mem, finished;
        int unsigned base, exp_cycles, mem_start, exp_pcen, exp_rw;
        int unsigned n_done, n_mw, n_req, n_ir, ir_at, n_pcen, n_ill;
        logic [2:0]  exp_alu, got_alu;
        logic [1:0]  last_pcsrc;
        logic        got_dst, got_m2r;

        fn_ok = (fn == 6'd32) || (fn == 6'd34) || (fn == 6'd36) || (fn == 6'd37) || (fn == 6'd42);
        legal = 1'b1;
        case (op)
            6'd0:    begin base = 4; legal = fn_ok; end
            6'd2:    base = 3;
            6'd4:    base = 3;
            6'd8:    base = 4;
            6'd35:   base = 5;
            6'd43:   base = 4;
            default: begin base = 2; legal = 1'b0; end
        endcase
        if (!legal) base = 2;
        is_mem     = legal && (op == 6'd35 || op == 6'd43);
        exp_cycles = base + wf + (is_mem ? wm : 0);
        mem_start  = wf + 3;
        exp_rw     = (legal && (op == 6'd0 || op == 6'd8 || op == 6'd35)) ? 1 : 0;
        exp_pcen   = 1 + ((legal && op == 6'd2) ? 1 : 0) + ((legal && op == 6'd4 && z) ? 1 : 0);
        case (fn)
            6'd34:   exp_alu = 3'b110;
            6'd36:   exp_alu = 3'b000;
            6'd37:   exp_alu = 3'b001;
            6'd42:   exp_alu = 3'b111;
            default: exp_alu = 3'b010;
        endcase

        Opcode = op;
        funct  = fn;
        finished = 1'b0;
        cycles = 0; n_rw = 0; n_done = 0; n_mw = 0; n_req = 0; n_ir = 0;
        ir_at = 99; n_pcen = 0; n_ill = 0;
        got_alu = 3'bxxx; got_dst = 1'bx; got_m2r = 1'bx; last_pcsrc = 2'bxx;

        for (int unsigned c = 0; c < 40 && !finished; c++) begin
            if (c < wf)                          mem_ready = 1'b0;
            else if (c == wf)                    mem_ready = 1'b1;
            else if (is_mem && c >= mem_start)   mem_ready = (c == mem_start + wm);
            else                                 mem_ready = 1'($urandom_range(0, 1));
            zero = (c == wf + 2) ? z : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 0) check("fetch_alusrcb", ALUSrcB, 1);
            if (legal && op == 6'd0 && c == wf + 2) got_alu = ALU_controls;
            if (regWrite)   begin n_rw++; got_dst = regDst; got_m2r = memToReg; end
            if (memWrite)   n_mw++;
            if (mem_req)    n_req++;
            if (IRWrite)    begin n_ir++; ir_at = c; end
            if (PCEn)       n_pcen++;
            if (illegal_op) n_ill++;
            if (instr_done) begin
                n_done++;
                cycles = c + 1;
                last_pcsrc = PCSrc;
                finished = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        check("cycles", cycles, exp_cycles);
        check("instr_done_count", n_done, 1);
        check("regwrite_count", n_rw, exp_rw);
        check("memwrite_cycles", n_mw, (legal && op == 6'd43) ? 1 + wm : 0);
        check("mem_req_cycles", n_req, wf + 1 + (is_mem ? 1 + wm : 0));
        check("irwrite_count", n_ir, 1);
        check("irwrite_cycle", ir_at, wf);
        check("pcen_count", n_pcen, exp_pcen);
        check("illegal_count", n_ill, legal ? 0 : 1);
        if (exp_rw == 1) begin
            check("regdst", got_dst, (op == 6'd0) ? 1 : 0);
            check("memtoreg", got_m2r, (op == 6'd35) ? 1 : 0);
        end
        if (legal && op == 6'd0) check("rtype_alu", got_alu, exp_alu);
        if (legal && op == 6'd4) check("branch_pcsrc", last_pcsrc, 1);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int unsigned wf;
        int unsigned wm;
        int unsigned exp_cycles;
        int unsigned exp_rw;
    } vec_t;

    initial begin
        vec_t        vecs[14];
        int unsigned cyc, rw, sel;
        logic [5:0]  op, fn;

        vecs[0]  = '{6'd0,  6'd32, 1'b0, 0, 0, 4, 1};  // add
        vecs[1]  = '{6'd35, 6'd0,  1'b0, 0, 2, 7, 1};  // lw, 2 MEMREAD waits
        vecs[2]  = '{6'd4,  6'd0,  1'b1, 0, 0, 3, 0};  // beq taken
        vecs[3]  = '{6'd4,  6'd0,  1'b0, 0, 0, 3, 0};  // beq not taken
        vecs[4]  = '{6'd43, 6'd0,  1'b0, 1, 0, 5, 0};  // sw, 1 FETCH wait
        vecs[5]  = '{6'd63, 6'd0,  1'b0, 0, 0, 2, 0};  // unsupported opcode
        vecs[6]  = '{6'd0,  6'd0,  1'b0, 0, 0, 2, 0};  // unsupported funct
        vecs[7]  = '{6'd2,  6'd0,  1'b0, 0, 0, 3, 0};  // j
        vecs[8]  = '{6'd8,  6'd0,  1'b0, 2, 0, 6, 1};  // addi, 2 FETCH waits
        vecs[9]  = '{6'd0,  6'd34, 1'b0, 0, 0, 4, 1};  // sub
        vecs[10] = '{6'd0,  6'd36, 1'b0, 0, 0, 4, 1};  // and
        vecs[11] = '{6'd0,  6'd37, 1'b0, 0, 0, 4, 1};  // or
        vecs[12] = '{6'd0,  6'd42, 1'b0, 0, 0, 4, 1};  // slt
        vecs[13] = '{6'd43, 6'd0,  1'b0, 0, 3, 7, 0};  // sw, 3 MEMWRITE waits

        rst_n = 1'b0; Opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].wf, vecs[i].wm, cyc, rw);
            check("table_cycles", cyc, vecs[i].exp_cycles);
            check("table_regwrite", rw, vecs[i].exp_rw);
        end

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom_range(0, 63));
            case (sel)
                0, 1: begin
                    op = 6'd0;
                    case ($urandom_range(0, 4))
                        0: fn = 6'd32;
                        1: fn = 6'd34;
                        2: fn = 6'd36;
                        3: fn = 6'd37;
                        default: fn = 6'd42;
                    endcase
                end
                2:       op = 6'd2;
                3:       op = 6'd4;
                4:       op = 6'd8;
                5, 6:    op = 6'd35;
                7:       op = 6'd43;
                8:       op = 6'($urandom_range(0, 63));
                default: op = 6'd0;
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), cyc, rw);
        end

        // Asynchronous reset while waiting in MEMREAD
        Opcode = 6'd35; funct = '0; mem_ready = 1'b1;       // FETCH, ready
        @(posedge clk); #1; mem_ready = 1'b0;               // DECODE
        @(posedge clk); #1;                                 // MEMADR
        @(posedge clk); #1;                                 // MEMREAD, stalled
        check("memread_req", {mem_req, IorD}, 3);
        #3 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs, 0);
        @(posedge clk); #1;
        check("reset_hold_outputs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state_after_release", outs, 0);
        @(posedge clk); #1;
        check("fetch_after_release", {mem_req, memWrite, regWrite}, 4);
        run_instr(6'd0, 6'd32, 1'b0, 1, 0, cyc, rw);
        check("post_reset_add_cycles", cyc, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle MIPS datapath: a Moore FSM with Mealy handshake terms that steps each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It drives the shared single memory (instruction and data), the IR, the register file, the ALU operand multiplexers and the PC enable. It supports R-type (add, sub, and, or, slt), addi, beq, j, lw and sw, with a ready/request handshake so memory may insert wait states.

## Interface
- No parameters; opcode, funct and state encodings are fixed constants (see Structure).
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- memWrite  out  1  access is a write (valid with mem_req)
- IorD  out  1  address mux: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR
- regDst  out  1  write register: 0=rt, 1=rd
- memToReg  out  1  writeback data: 0=ALUOut, 1=Data register
- regWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A register
- ALUSrcB  out  2  00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2
- ALU_controls  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction
- illegal_op  out  1  one-cycle pulse when an unsupported opcode/funct is decoded

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- RESET: held while rst_n low; every output 0. Always goes to FETCH on the first edge after release.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. Stays while mem_ready=0. When mem_ready=1, IRWrite=1 and PCEn=1 in that same cycle, then the FSM goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode: lw/sw→MEMADR; R→EXECUTE (funct in {32,34,36,37,42}) else illegal; addi(8)→ADDIEXEC; beq(4)→BRANCH; j(2)→JUMP; any other opcode is illegal. Illegal: illegal_op=1 and instr_done=1 this cycle, next FETCH, no state written.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw(35)→MEMREAD, sw(43)→MEMWRITE.
- MEMREAD: mem_req=1, IorD=1. Waits for mem_ready, then →MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1, instr_done=1, →FETCH.
- MEMWRITE: mem_req=1, memWrite=1, IorD=1. Waits for mem_ready; on ready instr_done=1 and →FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_controls from funct. →ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1, instr_done=1, →FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add. →ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1, instr_done=1, →FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. PCEn=zero. instr_done=1, →FETCH.
- JUMP: PCSrc=10, PCEn=1, instr_done=1, →FETCH.
- Any output not listed for a state is 0. ALU_controls defaults to 010.

## Timing
- State register: asynchronous clear to RESET on the rst_n falling edge, independent of clk. A reset mid-instruction aborts it; no partial regWrite or memWrite follows release.
- All outputs are combinational from state. PCEn (BRANCH) and IRWrite/PCEn/instr_done (FETCH, MEMWRITE) also depend on zero or mem_ready.
- Zero-wait cycle counts, FETCH to last state inclusive: beq 3, j 3, R 4, addi 4, sw 4, lw 5. Each mem_ready=0 cycle adds one.
- mem_req is held continuously until mem_ready. memWrite is constant during a write wait. mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Structure
- Package mips_pkg: opcode constants (R=0, j=2, beq=4, addi=8, lw=35, sw=43), funct constants (32, 34, 36, 37, 42), ALU_controls codes, ALUSrcB and PCSrc codes, and the state enumeration (4-bit binary).
- Sub-module alu_decoder: combinational funct→ALU_controls plus a valid flag, instantiated once. Used in EXECUTE and for the DECODE legality check.

## Test plan
- Reset: rst_n=0 mid-MEMREAD → state RESET and all outputs 0 asynchronously. After release, FETCH asserts mem_req=1 on the next edge.
- R-type add (Opcode=0, funct=32), mem_ready=1 → EXECUTE ALU_controls=010, ALUWB regWrite=1 regDst=1, instr_done on cycle 4.
- lw with mem_ready low 2 cycles in MEMREAD → mem_req held 3 cycles, memToReg=1 regWrite=1 in MEMWB, total 7 cycles.
- beq zero=1 → PCEn=1 PCSrc=01 in BRANCH. Rerun with zero=0 → PCEn=0. Both take 3 cycles.
- sw with 1 wait cycle in FETCH → IRWrite only on the ready cycle. memWrite=1 mem_req=1 in MEMWRITE, no regWrite.
- Opcode=6'd63 and Opcode=0/funct=6'd0 → illegal_op pulse in DECODE, next state FETCH, regWrite never asserted.
